// File: rtl/pmod_dac_spi_ctrl.sv
// Multi-channel SPI frame serialiser for PMOD DACs: PAD_BITS zeros then DATA_W bits MSB first.
// Optional DAC_AUTO_REPEAT_EN: relaunch from the last GAP cycle when start is held.
module pmod_dac_spi_ctrl #(
  parameter int NCH      = 2,
  parameter int DATA_W   = 12,
  parameter int PAD_BITS = 4,
  parameter int CLK_DIV  = 2,
  parameter int GAP_CYC  = 2
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [NCH*DATA_W-1:0] datain,
  output logic                  ready,
  output logic                  done,
  output logic                  sclk,
  output logic                  cs,
  output logic [NCH-1:0]        sdata
);

  localparam int FRAME = PAD_BITS + DATA_W;
  localparam int PW    = $clog2(2 * CLK_DIV);
  localparam int BW    = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int GW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t                     state, state_n;
  logic [PW-1:0]              phase, phase_n;
  logic [BW-1:0]              bitn, bitn_n;
  logic [GW-1:0]              gapn, gapn_n;
  logic [NCH-1:0][FRAME-1:0]  sh, sh_n, load_v;
  logic [NCH-1:0]             first_v, sdata_n;
  logic                       ready_n, done_n, sclk_n, cs_n, launch;

  // Zero-extension to FRAME bits supplies the leading pad zeros.
  always_comb begin
    load_v  = '0;
    first_v = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      load_v[c]  = FRAME'(datain[c*DATA_W +: DATA_W]);
      first_v[c] = load_v[c][FRAME-1];
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    bitn_n  = bitn;
    gapn_n  = gapn;
    sh_n    = sh;
    ready_n = ready;
    done_n  = 1'b0;
    sclk_n  = sclk;
    cs_n    = cs;
    sdata_n = sdata;
    launch  = 1'b0;
    case (state)
      IDLE: launch = start;
      SHIFT: begin
        if (phase == PW'(2 * CLK_DIV - 1)) begin
          if (bitn == BW'(FRAME - 1)) begin
            state_n = GAP;
            cs_n    = 1'b1;
            sclk_n  = 1'b1;
            sdata_n = '0;
            done_n  = 1'b1;
            gapn_n  = '0;
          end else begin
            bitn_n  = bitn + 1'b1;
            phase_n = '0;
            sclk_n  = 1'b1;
            for (int unsigned c = 0; c < NCH; c++) begin
              sh_n[c]    = sh[c] << 1;
              sdata_n[c] = sh_n[c][FRAME-1];
            end
          end
        end else begin
          phase_n = phase + 1'b1;
          if (phase == PW'(CLK_DIV - 1)) sclk_n = 1'b0;
        end
      end
      GAP: begin
        if (gapn == GW'(GAP_CYC - 1)) begin
`ifdef DAC_AUTO_REPEAT_EN
          if (start) begin
            launch = 1'b1;
          end else begin
            state_n = IDLE;
            ready_n = 1'b1;
          end
`else
          state_n = IDLE;
          ready_n = 1'b1;
`endif
        end else begin
          gapn_n = gapn + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (launch) begin
      state_n = SHIFT;
      sh_n    = load_v;
      sdata_n = first_v;
      cs_n    = 1'b0;
      sclk_n  = 1'b1;
      ready_n = 1'b0;
      phase_n = '0;
      bitn_n  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      phase <= '0;
      bitn  <= '0;
      gapn  <= '0;
      sh    <= '0;
      ready <= 1'b1;
      done  <= 1'b0;
      sclk  <= 1'b1;
      cs    <= 1'b1;
      sdata <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      bitn  <= bitn_n;
      gapn  <= gapn_n;
      sh    <= sh_n;
      ready <= ready_n;
      done  <= done_n;
      sclk  <= sclk_n;
      cs    <= cs_n;
      sdata <= sdata_n;
    end
  end

endmodule

// File: tb/tb_pmod_dac_spi_ctrl.sv
// Bench for pmod_dac_spi_ctrl: timeline model checked every cycle plus directed frame checks.
`timescale 1ns/1ps
module tb_pmod_dac_spi_ctrl;

`ifdef DAC_AUTO_REPEAT_EN
  localparam bit AUTO    = 1'b1;
  localparam int EXP_GAP = 2;
`else
  localparam bit AUTO    = 1'b0;
  localparam int EXP_GAP = 3;
`endif
  localparam int G   = 2;
  localparam int LA  = 64;
  localparam int LB  = 24;
  localparam int BIG = 100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, start, startb;
  logic [23:0] datain;
  logic [11:0] datainb;
  logic        ready, done, sclk, cs;
  logic [1:0]  sdata;
  logic        readyb, doneb, sclkb, csb;
  logic [0:0]  sdatab;

  pmod_dac_spi_ctrl dut_a (
    .clock(clk), .resetn(resetn), .start(start), .datain(datain),
    .ready(ready), .done(done), .sclk(sclk), .cs(cs), .sdata(sdata)
  );

  pmod_dac_spi_ctrl #(.NCH(1), .DATA_W(12), .PAD_BITS(0), .CLK_DIV(1), .GAP_CYC(2)) dut_b (
    .clock(clk), .resetn(resetn), .start(startb), .datain(datainb),
    .ready(readyb), .done(doneb), .sclk(sclkb), .cs(csb), .sdata(sdatab)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs r cycles after the accepting edge of the latest frame.
  function automatic void model(input int r, input int d, input int pad, input int dw,
                                input logic [11:0] s, output logic e_sclk, output logic e_cs,
                                output logic e_sd, output logic e_done, output logic e_rdy);
    int len, b;
    len = (pad + dw) * 2 * d;
    if (r < len) begin
      b      = r / (2 * d);
      e_sclk = (r % (2 * d)) < d;
      e_cs   = 1'b0;
      e_sd   = (b < pad) ? 1'b0 : s[dw - 1 - (b - pad)];
      e_done = 1'b0;
      e_rdy  = 1'b0;
    end else if (r < len + G) begin
      e_sclk = 1'b1; e_cs = 1'b1; e_sd = 1'b0; e_done = (r == len); e_rdy = 1'b0;
    end else begin
      e_sclk = 1'b1; e_cs = 1'b1; e_sd = 1'b0; e_done = 1'b0; e_rdy = 1'b1;
    end
  endfunction

  int          ra = BIG, rb = BIG;
  logic [11:0] sa0, sa1, sb;
  bit          mvalid = 1'b0;

  always @(posedge clk) begin
    if (resetn !== 1'b1) begin
      ra = BIG; rb = BIG; mvalid = 1'b1;
    end else begin
      if (start && (ra >= LA + G || (AUTO && ra == LA + G - 1))) begin
        sa0 = datain[11:0]; sa1 = datain[23:12]; ra = 0;
      end else if (ra < BIG) ra++;
      if (startb && (rb >= LB + G || (AUTO && rb == LB + G - 1))) begin
        sb = datainb; rb = 0;
      end else if (rb < BIG) rb++;
    end
  end

  logic es, ec, ed0, ed1, edn, er;
  always @(negedge clk) begin
    if (mvalid) begin
      model(ra, 2, 4, 12, sa0, es, ec, ed0, edn, er);
      model(ra, 2, 4, 12, sa1, es, ec, ed1, edn, er);
      chk("a_sclk", sclk, es);
      chk("a_cs", cs, ec);
      chk("a_done", done, edn);
      chk("a_ready", ready, er);
      chk("a_sdata0", sdata[0], ed0);
      chk("a_sdata1", sdata[1], ed1);
      model(rb, 1, 0, 12, sb, es, ec, ed0, edn, er);
      chk("b_sclk", sclkb, es);
      chk("b_cs", csb, ec);
      chk("b_done", doneb, edn);
      chk("b_ready", readyb, er);
      chk("b_sdata", sdatab[0], ed0);
    end
  end

  // Independent pin-level observers: DAC-side capture on sclk falls, cs run lengths.
  int          lowrun = 0, highrun = 0, lastlow = 0, falls = 0, dones = 0, launches = 0;
  int          gaps[8];
  logic [15:0] cap0 = '0, cap1 = '0;
  logic        prevcs = 1'b1, prevsclk = 1'b1;
  always @(negedge clk) begin
    if (prevcs === 1'b1 && cs === 1'b0) begin
      gaps[launches % 8] = highrun;
      launches++;
      highrun = 0; lowrun = 0; falls = 0; cap0 = '0; cap1 = '0;
    end
    if (cs === 1'b0) begin
      lowrun++;
      if (prevsclk === 1'b1 && sclk === 1'b0) begin
        cap0 = {cap0[14:0], sdata[0]};
        cap1 = {cap1[14:0], sdata[1]};
        falls++;
      end
    end else begin
      if (prevcs === 1'b0) lastlow = lowrun;
      highrun++;
    end
    if (done === 1'b1) dones++;
    prevcs = cs; prevsclk = sclk;
  end

  int          lowb = 0, lastlowb = 0, fallsb = 0;
  logic [11:0] capb = '0;
  logic        prevcsb = 1'b1, prevsclkb = 1'b1;
  always @(negedge clk) begin
    if (prevcsb === 1'b1 && csb === 1'b0) begin
      lowb = 0; fallsb = 0; capb = '0;
    end
    if (csb === 1'b0) begin
      lowb++;
      if (prevsclkb === 1'b1 && sclkb === 1'b0) begin
        capb = {capb[10:0], sdatab[0]};
        fallsb++;
      end
    end else if (prevcsb === 1'b0) lastlowb = lowb;
    prevcsb = csb; prevsclkb = sclkb;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int d0, b0;
  initial begin
    resetn = 1'b0; start = 1'b0; startb = 1'b0; datain = '0; datainb = '0;
    cyc(3);
    resetn = 1'b1;
    cyc(10);

    // Basic frame
    d0 = dones;
    datain = {12'h5A3, 12'hFFF};
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(70);
    chk("t2_cap0", cap0, 16'h0FFF);
    chk("t2_cap1", cap1, 16'h05A3);
    chk("t2_cs_low", lastlow, 64);
    chk("t2_falls", falls, 16);
    chk("t2_dones", dones - d0, 1);
    chk("t2_ready", ready, 1'b1);

    // Start and data changes during a frame are ignored
    d0 = dones;
    datain = {12'h123, 12'hABC};
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(10);
    start = 1'b1; datain = {12'hFFF, 12'h000}; cyc(1); start = 1'b0;
    cyc(30);
    datain = '0; start = 1'b1; cyc(1); start = 1'b0;
    cyc(30);
    chk("t3_cap0", cap0, 16'h0ABC);
    chk("t3_cap1", cap1, 16'h0123);
    chk("t3_dones", dones - d0, 1);

    // Mid-frame reset
    d0 = dones;
    datain = {12'h777, 12'h111};
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(29);
    resetn = 1'b0; cyc(1);
    chk("t4_cs", cs, 1'b1);
    chk("t4_sclk", sclk, 1'b1);
    chk("t4_sdata", sdata, 2'b00);
    resetn = 1'b1;
    cyc(80);
    chk("t4_no_done", dones - d0, 0);
    d0 = dones;
    datain = {12'h456, 12'h89A};
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(70);
    chk("t4_cap0", cap0, 16'h089A);
    chk("t4_cap1", cap1, 16'h0456);
    chk("t4_cs_low", lastlow, 64);
    chk("t4_dones", dones - d0, 1);

    // Start held for three frames
    b0 = launches;
    datain = {12'h321, 12'h654};
    start = 1'b1;
    for (int i = 0; i < 400 && launches - b0 < 3; i++) begin
      cyc(1);
      datain = (launches - b0 >= 2) ? {12'hC0F, 12'h3E1} :
               (launches - b0 >= 1) ? {12'h0F0, 12'h9D7} : {12'h321, 12'h654};
    end
    start = 1'b0;
    chk("t5_launches", launches - b0, 3);
    chk("t5_gap1", gaps[(b0 + 1) % 8], EXP_GAP);
    chk("t5_gap2", gaps[(b0 + 2) % 8], EXP_GAP);
    cyc(70);
    chk("t5_cap0", cap0, 16'h03E1);
    chk("t5_cap1", cap1, 16'h0C0F);

    // Fast, unpadded, single-channel configuration
    datainb = 12'hA5C;
    startb = 1'b1; cyc(1); startb = 1'b0;
    cyc(30);
    chk("t6_cap", capb, 12'hA5C);
    chk("t6_cs_low", lastlowb, 24);
    chk("t6_falls", fallsb, 12);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
